alu_regfile_seq: RTL and testbench

- Parametrised successor to the 8-bit register/ALU/control datapath.
- Holds an NREGS x DATA_W register file.
- Accepts three-address instructions over a valid/ready handshake and executes them.
- Single-cycle ops use one execute state; DIV/MOD use an iterative restoring divider.
- Results are written back with registered flags and a one-cycle completion strobe.
- Sits between the instruction source (sequencer/testbench) and the result consumer.

---
 rtl/alu_regfile_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_regfile_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq
//   Register file plus ALU with a small control FSM. It accepts one
//   three-address instruction at a time over a valid/ready handshake,
//   executes it, and writes the result back to the register file. Single-cycle
//   ops spend one cycle in EXEC. DIV/MOD spend DATA_W cycles in an iterative
//   restoring divider (DIV state).
//
//   Optional feature: define ALU_SAT_EN so that ADD/SUB clamp to the signed
//   max/min on signed overflow. The default build wraps modulo 2^DATA_W.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   instr          {opcode[3:0], rd, rs1, rs2}; opcode at MSBs, rs2 at LSBs
//   instr_valid    instr is valid
//   instr_ready    high only in IDLE
//   result         last committed result, held until the next commit
//   result_valid   one-cycle pulse per completed instruction
//   zero_flag      registered zero flag
//   carry_flag     registered carry/borrow flag
//   overflow_flag  registered overflow flag
//   busy           high in EXEC or DIV
//   dbg_addr       debug read address
//   dbg_data       combinational read of reg[dbg_addr]
module alu_regfile_seq #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = $clog2(NREGS),
    parameter int INSTR_W = 4 + 3 * ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               overflow_flag,
    output logic               busy,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV} state_t;

`ifdef ALU_SAT_EN
    // Clamp value for a signed overflow; the sign of operand A decides the
    // direction for both ADD and SUB.
    function automatic logic [DATA_W-1:0] sat_clamp(input logic neg);
        return neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
`endif

    state_t                    state;
    logic [DATA_W-1:0]         regs [NREGS];

    logic [3:0]                op_p0;
    logic [ADDR_W-1:0]         rd_p0;
    logic [DATA_W-1:0]         opa_p0;
    logic [DATA_W-1:0]         opb_p0;
    logic [DATA_W-1:0]         quo_p1;
    logic [DATA_W-1:0]         rem_p1;
    logic [CNT_W-1:0]          cnt_p1;

    logic [3:0]                op_in;
    logic [ADDR_W-1:0]         rd_in;
    logic [ADDR_W-1:0]         rs1_in;
    logic [ADDR_W-1:0]         rs2_in;
    logic                      accept;

    assign op_in  = instr[INSTR_W-1 -: 4];
    assign rd_in  = instr[3*ADDR_W-1 -: ADDR_W];
    assign rs1_in = instr[2*ADDR_W-1 -: ADDR_W];
    assign rs2_in = instr[ADDR_W-1:0];

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = instr_ready && instr_valid;
    assign dbg_data    = regs[dbg_addr];

    // ---- stage p0 -> commit: single-cycle ALU on latched operands ----
    logic [DATA_W:0]           usum_p0;
    logic [DATA_W:0]           udif_p0;
    logic [2*DATA_W-1:0]       prod_p0;
    logic                      add_ovf_p0;
    logic                      sub_ovf_p0;
    logic [DATA_W-1:0]         alu_res;
    logic                      alu_c;
    logic                      alu_v;
    logic                      alu_wr;

    assign usum_p0 = {1'b0, opa_p0} + {1'b0, opb_p0};
    assign udif_p0 = {1'b0, opa_p0} - {1'b0, opb_p0};
    assign prod_p0 = {{DATA_W{1'b0}}, opa_p0} * {{DATA_W{1'b0}}, opb_p0};
    assign add_ovf_p0 = (opa_p0[DATA_W-1] == opb_p0[DATA_W-1]) &&
                        (usum_p0[DATA_W-1] != opa_p0[DATA_W-1]);
    assign sub_ovf_p0 = (opa_p0[DATA_W-1] != opb_p0[DATA_W-1]) &&
                        (udif_p0[DATA_W-1] != opa_p0[DATA_W-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        case (op_p0)
            OP_ADD: begin
                alu_res = usum_p0[DATA_W-1:0];
                alu_c   = usum_p0[DATA_W];
                alu_v   = add_ovf_p0;
`ifdef ALU_SAT_EN
                if (add_ovf_p0) alu_res = sat_clamp(opa_p0[DATA_W-1]);
`endif
            end
            OP_SUB: begin
                alu_res = udif_p0[DATA_W-1:0];
                alu_c   = udif_p0[DATA_W];
                alu_v   = sub_ovf_p0;
`ifdef ALU_SAT_EN
                if (sub_ovf_p0) alu_res = sat_clamp(opa_p0[DATA_W-1]);
`endif
            end
            OP_MUL: begin
                alu_res = prod_p0[DATA_W-1:0];
                alu_c   = |prod_p0[2*DATA_W-1:DATA_W];
            end
            OP_AND:  alu_res = opa_p0 & opb_p0;
            OP_OR:   alu_res = opa_p0 | opb_p0;
            OP_XOR:  alu_res = opa_p0 ^ opb_p0;
            OP_NOT:  alu_res = ~opa_p0;
            OP_MOV:  alu_res = opa_p0;
            default: alu_wr  = 1'b0;
        endcase
    end

    // ---- stage p1: one restoring-divide step per cycle ----
    // A zero divisor needs no special case: every trial subtraction succeeds,
    // leaving an all-ones quotient and the dividend as remainder.
    logic [DATA_W:0]           div_shl;
    logic [DATA_W:0]           div_sub;
    logic [DATA_W-1:0]         quo_nx;
    logic [DATA_W-1:0]         rem_nx;
    logic [DATA_W-1:0]         div_res;

    assign div_shl = {rem_p1, quo_p1[DATA_W-1]};
    assign div_sub = div_shl - {1'b0, opb_p0};
    assign rem_nx  = div_sub[DATA_W] ? div_shl[DATA_W-1:0] : div_sub[DATA_W-1:0];
    assign quo_nx  = {quo_p1[DATA_W-2:0], ~div_sub[DATA_W]};
    assign div_res = (op_p0 == OP_DIV) ? quo_nx : rem_nx;

    // ---- operand / divider datapath registers (no reset needed) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_p0 <= regs[rs1_in];
            opb_p0 <= regs[rs2_in];
            quo_p1 <= regs[rs1_in];
            rem_p1 <= '0;
        end else if (state == S_DIV) begin
            quo_p1 <= quo_nx;
            rem_p1 <= rem_nx;
        end
    end

    // ---- control FSM, register file and commit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_p0         <= '0;
            rd_p0         <= '0;
            cnt_p1        <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(i);
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_p0  <= op_in;
                        rd_p0  <= rd_in;
                        cnt_p1 <= '0;
                        state  <= (op_in == OP_DIV || op_in == OP_MOD) ? S_DIV : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_valid <= 1'b1;
                    if (alu_wr) begin
                        regs[rd_p0]   <= alu_res;
                        result        <= alu_res;
                        zero_flag     <= (alu_res == '0);
                        carry_flag    <= alu_c;
                        overflow_flag <= alu_v;
                    end
                    state <= S_IDLE;
                end
                S_DIV: begin
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                    if (cnt_p1 == CNT_LAST) begin
                        result_valid  <= 1'b1;
                        regs[rd_p0]   <= div_res;
                        result        <= div_res;
                        zero_flag     <= (div_res == '0);
                        carry_flag    <= 1'b0;
                        overflow_flag <= (opb_p0 == '0);
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Testbench for alu_regfile_seq: a reference model computes each expected
// result at accept time and pushes it to a scoreboard queue; a monitor pops
// and compares on every result_valid pulse, including the accept-to-valid
// latency.
module tb_alu_regfile_seq;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int IW = 4 + 3 * AW;
    localparam int UMAX = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          zero_flag;
    logic          carry_flag;
    logic          overflow_flag;
    logic          busy;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    alu_regfile_seq #(.DATA_W(W), .NREGS(N)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .result(result), .result_valid(result_valid),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, v;
        time          t_acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_res;
    logic         m_z, m_c, m_v;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = W'(i);
        m_res = '0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
    endtask

    task automatic model_exec(input int op, input int rd, input int a, input int b);
        int r, sa, sb_, ss;
        logic wr, c, v;
        wr = 1'b1; c = 1'b0; v = 1'b0; r = 0; ss = 0;
        sa  = (a > SMAX) ? a - (UMAX + 1) : a;
        sb_ = (b > SMAX) ? b - (UMAX + 1) : b;
        case (op)
            0: begin
                r = a + b; c = (r > UMAX); r = r & UMAX;
                ss = sa + sb_; v = (ss > SMAX) || (ss < SMIN);
`ifdef ALU_SAT_EN
                if (v) r = (ss > SMAX) ? SMAX : (UMAX + 1) / 2;
`endif
            end
            1: begin
                c = (a < b); r = (a - b) & UMAX;
                ss = sa - sb_; v = (ss > SMAX) || (ss < SMIN);
`ifdef ALU_SAT_EN
                if (v) r = (ss > SMAX) ? SMAX : (UMAX + 1) / 2;
`endif
            end
            2: begin r = a * b; c = (r > UMAX); r = r & UMAX; end
            3: if (b == 0) begin r = UMAX; v = 1'b1; end else r = a / b;
            4: if (b == 0) begin r = a;    v = 1'b1; end else r = a % b;
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: r = (~a) & UMAX;
            9: r = a;
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_regs[rd] = W'(r);
            m_res = W'(r); m_z = (r == 0); m_c = c; m_v = v;
        end
    endtask

    // Present an instruction, hold it until accepted, then log the expectation.
    // waits = number of falling edges at which instr_ready was seen low.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        instr = {op[3:0], rd[AW-1:0], rs1[AW-1:0], rs2[AW-1:0]};
        instr_valid = 1'b1;
        while (!instr_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        check_val("accept_ready", instr_ready, 1);
        @(posedge clk);
        model_exec(op, rd, m_regs[rs1], m_regs[rs2]);
        e.res = m_res; e.z = m_z; e.c = m_c; e.v = m_v;
        e.t_acc = $time;
        e.lat = (op == 3 || op == 4) ? W + 1 : 2;
        sb.push_back(e);
        #1 instr_valid = 1'b0;
    endtask

    task automatic go(input int op, input int rd, input int rs1, input int rs2);
        int w;
        issue(op, rd, rs1, rs2, w);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || !instr_ready) && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_val("drain_queue", sb.size(), 0);
    endtask

    task automatic check_regs();
        for (int i = 0; i < N; i++) begin
            dbg_addr = AW'(i);
            #1;
            check_val($sformatf("reg%0d", i), dbg_data, m_regs[i]);
        end
    endtask

    task automatic check_flags();
        check_val("result", result, m_res);
        check_val("zero_flag", zero_flag, m_z);
        check_val("carry_flag", carry_flag, m_c);
        check_val("overflow_flag", overflow_flag, m_v);
    endtask

    // result_valid seen high after commit edge X means it is high at edge X+1;
    // latency counts edges from the accept edge to that edge.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", result_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("sb_result", result, mon_e.res);
                check_val("sb_zero", zero_flag, mon_e.z);
                check_val("sb_carry", carry_flag, mon_e.c);
                check_val("sb_ovf", overflow_flag, mon_e.v);
                check_val("sb_latency", int'((($time + 5) - mon_e.t_acc) / 10), mon_e.lat);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check_regs();
        check_flags();
        check_val("ready_after_reset", instr_ready, 1);
        check_val("busy_after_reset", busy, 0);
        check_val("valid_after_reset", result_valid, 0);

        // ADD and dependent ADD
        go(0, 3, 1, 2);
        go(0, 4, 3, 3);
        wait_drain();
        check_regs();
        dbg_addr = 3'd4; #1;
        check_val("plan_add_dep", dbg_data, 8'h06);

        // SUB with borrow, SUB to zero
        go(1, 5, 1, 2);
        wait_drain();
        check_val("plan_sub_res", result, 8'hFF);
        check_val("plan_sub_borrow", carry_flag, 1);
        go(1, 6, 2, 2);
        wait_drain();
        check_val("plan_sub_zero", zero_flag, 1);

        // DIV / MOD / divide by zero
        go(3, 3, 7, 2);
        go(4, 4, 7, 2);
        go(3, 5, 7, 0);
        wait_drain();
        check_regs();
        check_flags();
        check_val("plan_div0_ovf", overflow_flag, 1);
        dbg_addr = 3'd3; #1;
        check_val("plan_div", dbg_data, 8'h03);
        dbg_addr = 3'd4; #1;
        check_val("plan_mod", dbg_data, 8'h01);

        // MUL chain and signed overflow on ADD
        go(0, 6, 3, 3);
        go(2, 4, 6, 3);
        go(2, 6, 7, 4);
        wait_drain();
        check_val("plan_mul", result, 8'h7E);
        go(0, 6, 6, 2);
        wait_drain();
`ifdef ALU_SAT_EN
        check_val("plan_add_ovf", result, 8'h7F);
`else
        check_val("plan_add_ovf", result, 8'h80);
`endif
        check_val("plan_add_ovf_flag", overflow_flag, 1);
        check_flags();

        // logic ops and NOP
        go(5, 1, 7, 6);
        go(6, 2, 4, 5);
        go(7, 0, 6, 7);
        go(8, 3, 5, 0);
        go(9, 7, 2, 0);
        go(13, 0, 1, 2);
        wait_drain();
        check_regs();
        check_flags();

        // instruction held valid while a divide runs
        go(3, 1, 6, 2);
        issue(0, 2, 1, 1, w);
        check_val("held_during_div", w, W);
        wait_drain();
        check_regs();

        // random mix
        for (int i = 0; i < 30; i++)
            go($urandom_range(0, 15), $urandom_range(0, N - 1),
               $urandom_range(0, N - 1), $urandom_range(0, N - 1));
        wait_drain();
        check_regs();
        check_flags();

        // reset in the middle of a divide
        go(3, 2, 7, 1);
        @(negedge clk);
        check_val("busy_in_div", busy, 1);
        check_val("ready_in_div", instr_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_val("ready_in_reset", instr_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_regs();
        check_flags();
        check_val("busy_after_abort", busy, 0);

        // operation after abort
        go(0, 0, 7, 7);
        wait_drain();
        check_regs();
        check_flags();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
